// File: rtl/div_pkg.sv
// div_pkg: shared defaults, FSM states and constants for the quotient/remainder BCD converter
package div_pkg;
  localparam int DEF_SIZE = 32;
  localparam int DEF_DIGITS = 10;
  localparam logic [3:0] BCD_BLANK = 4'hF;
  typedef enum logic [1:0] {IDLE, CONV_Q, CONV_R, DONE} state_t;
  function automatic int cnt_w(input int size);
    return $clog2(size + 1);
  endfunction
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble digit cell, adds 3 to any digit of 5 or more
module bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] y
);
  assign y = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/div_result_bcd.sv
// div_result_bcd: serial double-dabble conversion of divider quotient then remainder to packed BCD
module div_result_bcd
  import div_pkg::*;
#(
  parameter int SIZE = DEF_SIZE,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [SIZE-1:0]     quotient,
  input  logic [SIZE-1:0]     remainder,
  input  logic                div_err,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [4*DIGITS-1:0] q_bcd,
  output logic [4*DIGITS-1:0] r_bcd
);
  localparam int CW = cnt_w(SIZE);
  localparam int BW = 4 * DIGITS;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SIZE-1:0] bin_q, bin_d, rem_q, rem_d;
  logic [BW-1:0] acc_q, acc_d, q_hold_q, q_hold_d, q_bcd_q, q_bcd_d, r_bcd_q, r_bcd_d;
  logic derr_q, derr_d, err_q, err_d, done_q, done_d;
  logic [BW-1:0] adj, shifted;
  logic conv, last;
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (.d(acc_q[4*i +: 4]), .y(adj[4*i +: 4]));
  end
  assign conv = (state_q == CONV_Q) || (state_q == CONV_R);
  assign last = cnt_q == CW'(1);
  assign shifted = (adj << 1) | {{(BW-1){1'b0}}, bin_q[SIZE-1]};
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bin_q    <= '0;
      rem_q    <= '0;
      acc_q    <= '0;
      q_hold_q <= '0;
      derr_q   <= 1'b0;
      q_bcd_q  <= '0;
      r_bcd_q  <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      rem_q    <= rem_d;
      acc_q    <= acc_d;
      q_hold_q <= q_hold_d;
      derr_q   <= derr_d;
      q_bcd_q  <= q_bcd_d;
      r_bcd_q  <= r_bcd_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? (div_err ? DONE : CONV_Q) : IDLE;
      CONV_Q:  state_d = last ? CONV_R : CONV_Q;
      CONV_R:  state_d = last ? DONE : CONV_R;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    rem_d    = rem_q;
    acc_d    = acc_q;
    q_hold_d = q_hold_q;
    derr_d   = derr_q;
    q_bcd_d  = q_bcd_q;
    r_bcd_d  = r_bcd_q;
    err_d    = err_q;
    done_d   = 1'b0;
    if (state_q == IDLE && start) begin
      bin_d  = quotient;
      rem_d  = remainder;
      derr_d = div_err;
      acc_d  = '0;
      cnt_d  = CW'(SIZE);
    end
    if (conv) begin
      bin_d = {bin_q[SIZE-2:0], 1'b0};
      acc_d = shifted;
      cnt_d = cnt_q - 1'b1;
    end
    if (state_q == CONV_Q && last) begin
      q_hold_d = shifted;
      bin_d    = rem_q;
      acc_d    = '0;
      cnt_d    = CW'(SIZE);
    end
    if (state_q == DONE) begin
      q_bcd_d = derr_q ? {DIGITS{BCD_BLANK}} : q_hold_q;
      r_bcd_d = derr_q ? {DIGITS{BCD_BLANK}} : acc_q;
      err_d   = derr_q;
      done_d  = 1'b1;
    end
  end
  assign busy  = conv;
  assign done  = done_q;
  assign err   = err_q;
  assign q_bcd = q_bcd_q;
  assign r_bcd = r_bcd_q;
endmodule

// File: tb/tb_div_result_bcd.sv
// tb_div_result_bcd: scoreboard bench for the BCD result converter
module tb_div_result_bcd;
  logic clk = 1'b0;
  logic reset, start, div_err, busy, done, err;
  logic [31:0] quotient, remainder;
  logic [39:0] q_bcd, r_bcd;
  int checks = 0, errors = 0, cyc = 0, busy_cnt = 0;
  typedef struct {
    logic [39:0] q;
    logic [39:0] r;
    logic        e;
    int          n;
    int          lat;
  } exp_t;
  exp_t sb[$];
  exp_t x;
  div_result_bcd dut (
    .clk(clk), .reset(reset), .start(start), .quotient(quotient), .remainder(remainder),
    .div_err(div_err), .busy(busy), .done(done), .err(err), .q_bcd(q_bcd), .r_bcd(r_bcd)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [39:0] to_bcd(input logic [31:0] v);
    logic [39:0] b = '0;
    for (int i = 0; i < 10; i++) begin
      b[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return b;
  endfunction
  always @(negedge clk) begin
    if (!reset) begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) check("spurious_done", 64'(done), 64'd0);
        else begin
          x = sb.pop_front();
          check("q_bcd", 64'(q_bcd), 64'(x.q));
          check("r_bcd", 64'(r_bcd), 64'(x.r));
          check("err", 64'(err), 64'(x.e));
          check("latency", 64'(cyc - x.n), 64'(x.lat));
        end
      end
    end
  end
  task automatic req(input logic [31:0] q, input logic [31:0] r, input logic e);
    @(negedge clk);
    quotient = q;
    remainder = r;
    div_err = e;
    start = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{e ? 40'hFFFFFFFFFF : to_bcd(q), e ? 40'hFFFFFFFFFF : to_bcd(r), e, cyc, e ? 1 : 65});
    start = 1'b0;
    div_err = 1'b0;
    quotient = $urandom;
    remainder = $urandom;
  endtask
  task automatic wait_idle();
    int t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("timeout", 64'(sb.size()), 64'd0);
  endtask
  initial begin
    reset = 1'b1;
    start = 1'b0;
    div_err = 1'b0;
    quotient = '0;
    remainder = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_q", 64'(q_bcd), 64'd0);
    check("rst_r", 64'(r_bcd), 64'd0);
    reset = 1'b0;
    busy_cnt = 0;
    req(32'd1234, 32'd56, 1'b0);
    wait_idle();
    check("busy_cycles", 64'(busy_cnt), 64'd64);
    req(32'hFFFFFFFF, 32'd0, 1'b0);
    wait_idle();
    req(32'd100, 32'd7, 1'b0);
    repeat (8) @(negedge clk);
    quotient = 32'd999;
    remainder = 32'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    req(32'd5, 32'd0, 1'b1);
    wait_idle();
    req(32'd0, 32'd0, 1'b0);
    wait_idle();
    req(32'd12345, 32'd678, 1'b0);
    repeat (45) @(negedge clk);
    check("busy_mid", 64'(busy), 64'd1);
    sb.delete();
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_done", 64'(done), 64'd0);
    check("mid_q", 64'(q_bcd), 64'd0);
    check("mid_r", 64'(r_bcd), 64'd0);
    check("mid_err", 64'(err), 64'd0);
    reset = 1'b0;
    repeat (80) @(negedge clk);
    req(32'd42, 32'd5, 1'b0);
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      req($urandom, $urandom, 1'b0);
      wait_idle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
